uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_rx_sync2.sv | 23 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 8;
  localparam int unsigned DATA_BITS_DEF  = 8;

  // Majority-vote sample points inside a bit, counted in baud_fast ticks
  localparam int unsigned SAMPLE_A    = 2;
  localparam int unsigned SAMPLE_B    = 3;
  localparam int unsigned SAMPLE_C    = 4;
  localparam int unsigned START_CHECK = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle of the UART receiver; master is the receiver side.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS_DEF
);

  logic                 baud_fast;
  logic                 rxd;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (
    input  baud_fast, rxd,
    output data, valid, frame_err, busy, parity_err
  );

  modport slave (
    output baud_fast, rxd,
    input  data, valid, frame_err, busy, parity_err
  );
`else
  modport master (
    input  baud_fast, rxd,
    output data, valid, frame_err, busy
  );

  modport slave (
    output baud_fast, rxd,
    input  data, valid, frame_err, busy
  );
`endif

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample majority per bit, LSB first, one stop bit.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input logic      clk,
  input logic      nreset,
  uart_rx_if.master bus
);

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic [TW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [1:0]           samp, samp_next;
  logic [DATA_BITS-1:0] data_q, data_next;
  logic                 valid_q, valid_next;
  logic                 ferr_q, ferr_next;
  logic                 busy_q, busy_next;
  logic                 rxd_s;
  logic                 bit_maj;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_next;
  logic                 perr_q, perr_next;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (bus.rxd),
    .q      (rxd_s)
  );

  // Everything advances on baud_fast only; valid/err pulses self-clear each clk.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    samp_next  = samp;
    data_next  = data_q;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next   = par_bit;
    perr_next  = 1'b0;
`endif
    bit_maj    = maj3(samp[0], samp[1], rxd_s);

    if (bus.baud_fast) begin
      tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      if (tick_cnt == TW'(SAMPLE_A)) samp_next[0] = rxd_s;
      if (tick_cnt == TW'(SAMPLE_B)) samp_next[1] = rxd_s;

      case (state)
        IDLE: begin
          // The detecting tick is tick 0 of the start bit
          if (rxd_s) tick_next  = '0;
          else       state_next = START;
        end

        START: begin
          // Confirmed at mid-bit; DATA begins on the start bit's last tick so
          // data tick counts stay aligned to bit boundaries.
          if (tick_cnt == TW'(START_CHECK) && rxd_s) begin
            state_next = IDLE;
            tick_next  = '0;
          end else if (tick_cnt == TICK_LAST) begin
            state_next = DATA;
            bit_next   = '0;
          end
        end

        DATA: begin
          if (tick_cnt == TW'(SAMPLE_C)) begin
            shift_next = {bit_maj, shift[DATA_BITS-1:1]};
          end
          if (tick_cnt == TICK_LAST) begin
            if (bit_cnt == BIT_LAST) begin
              bit_next = '0;
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_cnt + BW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == TW'(SAMPLE_C)) par_next = bit_maj;
          if (tick_cnt == TICK_LAST) state_next = STOP;
        end
`endif

        STOP: begin
          // Leave at mid-bit so a start edge right after the stop bit is caught
          if (tick_cnt == TW'(SAMPLE_C)) begin
            valid_next = 1'b1;
            ferr_next  = ~bit_maj;
            data_next  = shift;
`ifdef UART_RX_PARITY_EN
            perr_next  = (^shift) ^ par_bit;
`endif
            state_next = IDLE;
            tick_next  = '0;
          end
        end

        default: begin
          state_next = IDLE;
          tick_next  = '0;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      samp     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      samp     <= samp_next;
      data_q   <= data_next;
      valid_q  <= valid_next;
      ferr_q   <= ferr_next;
      busy_q   <= busy_next;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_next;
      perr_q   <= perr_next;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are queued as expectations when sent
// and matched against what the receiver reports on valid.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned OS       = OVERSAMPLE_DEF;
  localparam int unsigned DB       = DATA_BITS_DEF;
  localparam int unsigned TICK_DIV = 8;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } res_t;

  logic clk = 1'b0;
  logic nreset;
  logic tick_en = 1'b1;
  int unsigned div_cnt;
  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  int busy_run = 0;
  int busy_last = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  // baud_fast: one-clk pulse every TICK_DIV clocks, stoppable via tick_en
  initial begin
    div_cnt = 0;
    bus.baud_fast = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div_cnt = (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
        bus.baud_fast = (div_cnt == 0);
      end else begin
        bus.baud_fast = 1'b0;
      end
    end
  end

  // Output monitor: records every valid pulse and busy run lengths
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        busy_last = busy_run;
        busy_run  = 0;
      end
      if (bus.valid === 1'b1) begin
        valid_cnt++;
        r.data = bus.data;
        r.ferr = bus.frame_err;
`ifdef UART_RX_PARITY_EN
        r.perr = bus.parity_err;
`else
        r.perr = 1'b0;
`endif
        obs_q.push_back(r);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    do @(posedge clk); while (bus.baud_fast !== 1'b1);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rxd = b;
    repeat (OS) wait_tick();
  endtask

  task automatic idle_ticks(input int n);
    bus.rxd = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Half the bit is sent, then ticks stop while rxd glitches, then the rest.
  task automatic send_bit_paused(input logic b);
    bus.rxd = b;
    repeat (OS / 2) wait_tick();
    tick_en = 1'b0;
    repeat (40) begin
      @(negedge clk);
      bus.rxd = ~bus.rxd;
    end
    bus.rxd = b;
    repeat (4) @(negedge clk);
    tick_en = 1'b1;
    repeat (OS - OS / 2) wait_tick();
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop, input int pause_bit);
    res_t e;
    e.data = b;
    e.ferr = ~stop;
    e.perr = 1'b0;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) begin
      if (i == pause_bit) send_bit_paused(b[i]);
      else                send_bit(b[i]);
    end
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    bus.rxd = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", bus.valid); end
    n_tests++;
    if (bus.data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", bus.data); end
    n_tests++;
    if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", bus.frame_err); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    nreset = 1'b1;
    idle_ticks(2 * OS);
  endtask

  task automatic test_single();
    res_t o, e;
    int v0 = valid_cnt;
    send_frame(8'h55, 1'b1, -1);
    idle_ticks(OS);
    n_tests++;
    if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL single_pulses: got %0d valid pulses, expected 1", valid_cnt - v0); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b after frame, expected 0", bus.busy); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL single_frame: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b", o.data, o.ferr, o.perr, e.data, e.ferr, e.perr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    idle_ticks(OS);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_frame: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b", o.data, o.ferr, o.perr, e.data, e.ferr, e.perr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_false_start();
    int v0 = valid_cnt;
    busy_last = 0;
    bus.rxd = 1'b0;
    repeat (2) wait_tick();
    idle_ticks(3 * OS);
    n_tests++;
    if (valid_cnt != v0) begin n_fail++; $display("FAIL false_start_valid: got %0d pulses, expected 0", valid_cnt - v0); end
    n_tests++;
    if (busy_last == 0 || busy_last > int'(3 * TICK_DIV)) begin n_fail++; $display("FAIL false_start_busy: busy lasted %0d clks, expected 1..%0d", busy_last, 3 * TICK_DIV); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: got busy=%b, expected 0", bus.busy); end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    res_t o, e;
    send_frame(8'h81, 1'b0, -1);
    idle_ticks(2 * OS);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ferr_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL ferr_frame: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b", o.data, o.ferr, o.perr, e.data, e.ferr, e.perr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    res_t o, e;
    int v0 = valid_cnt;
    send_bit(1'b0);
    bus.rxd = 1'b1;
    repeat (4 * OS + OS / 2) wait_tick();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.data !== '0) begin n_fail++; $display("FAIL abort_data: got %h during reset, expected 00", bus.data); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b during reset, expected 0", bus.busy); end
    nreset = 1'b1;
    idle_ticks(2 * OS);
    n_tests++;
    if (valid_cnt != v0) begin n_fail++; $display("FAIL abort_valid: got %0d pulses for aborted frame, expected 0", valid_cnt - v0); end
    send_frame(8'h12, 1'b1, -1);
    idle_ticks(OS);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL abort_frame: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b", o.data, o.ferr, o.perr, e.data, e.ferr, e.perr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_tick_pause();
    res_t o, e;
    send_frame(8'h5A, 1'b1, 3);
    idle_ticks(OS);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pause_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL pause_frame: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b", o.data, o.ferr, o.perr, e.data, e.ferr, e.perr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    res_t o, e;
    logic [DB-1:0] b = 8'h07;
    for (int p = 0; p < 2; p++) begin
      e.data = b;
      e.ferr = 1'b0;
      e.perr = (^b) ^ p[0];
      exp_q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < int'(DB); i++) send_bit(b[i]);
      send_bit(p[0]);
      send_bit(1'b1);
    end
    idle_ticks(OS);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL parity_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL parity_frame: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b", o.data, o.ferr, o.perr, e.data, e.ferr, e.perr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    bus.rxd = 1'b1;
    nreset  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid_frame();
    test_tick_pause();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
